// File: rtl/rob_multi_wb.sv
// Reorder buffer with in-order allocate/commit and NUM_WB out-of-order writeback channels.
// Each ROB slot is a rob_entry instance; the top owns the head/tail pointers and writeback decode.

module rob_entry #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_alloc_we,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_inst,
    input  logic [PREG_W-1:0] i_prd,
    input  logic              i_wb_we,
    input  logic [DATA_W-1:0] i_wb_value,
    input  logic              i_commit_clr,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_inst,
    output logic [PREG_W-1:0] o_prd,
    output logic [DATA_W-1:0] o_value
);
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic [PREG_W-1:0] r_prd;
    logic [DATA_W-1:0] r_value;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_prd   <= '0;
            r_value <= '0;
        end else if (i_flush) begin
            // Flush only drops status; payload storage is left as is.
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (i_wb_we) begin
                r_done  <= 1'b1;
                r_value <= i_wb_value;
            end
            if (i_commit_clr) begin
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end
            if (i_alloc_we) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_pc   <= i_pc;
                r_inst <= i_inst;
                r_prd  <= i_prd;
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_prd   = r_prd;
    assign o_value = r_value;
endmodule

module rob_multi_wb #(
    parameter int NUM_ENTRIES = 32,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int NUM_WB      = 3,
    parameter int DATA_W      = 32,
    parameter int PREG_W      = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     flush_i,
    input  logic                     alloc_valid_i,
    output logic                     alloc_ready_o,
    input  logic [PREG_W-1:0]        alloc_prd_i,
    input  logic [31:0]              alloc_pc_i,
    input  logic [31:0]              alloc_inst_i,
    output logic [IDX_W-1:0]         alloc_idx_o,
    input  logic [NUM_WB-1:0]        wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]  wb_idx_i,
    input  logic [NUM_WB*DATA_W-1:0] wb_value_i,
    output logic                     commit_valid_o,
    input  logic                     commit_ready_i,
    output logic [IDX_W-1:0]         commit_idx_o,
    output logic [31:0]              commit_pc_o,
    output logic [31:0]              commit_inst_o,
    output logic [PREG_W-1:0]        commit_prd_o,
    output logic [DATA_W-1:0]        commit_value_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [IDX_W:0]           count_o
);
    localparam logic [IDX_W:0] PTR_ONE = 1;

    logic [IDX_W:0] r_head;
    logic [IDX_W:0] r_tail;

    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_empty;
    logic             w_full;
    logic             w_alloc_fire;
    logic             w_commit_fire;

    logic [NUM_ENTRIES-1:0]             w_busy;
    logic [NUM_ENTRIES-1:0]             w_done;
    logic [NUM_ENTRIES-1:0][31:0]       w_pc;
    logic [NUM_ENTRIES-1:0][31:0]       w_inst;
    logic [NUM_ENTRIES-1:0][PREG_W-1:0] w_prd;
    logic [NUM_ENTRIES-1:0][DATA_W-1:0] w_value;
    logic [NUM_ENTRIES-1:0]             w_wb_hit;
    logic [NUM_ENTRIES-1:0][DATA_W-1:0] w_wb_val;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

    assign alloc_ready_o  = !w_full && !flush_i;
    assign commit_valid_o = !w_empty && w_done[w_head_idx] && !flush_i;
    assign w_alloc_fire   = alloc_valid_i && alloc_ready_o;
    assign w_commit_fire  = commit_valid_o && commit_ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_ni || flush_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_alloc_fire)  r_tail <= r_tail + PTR_ONE;
            if (w_commit_fire) r_head <= r_head + PTR_ONE;
        end
    end

    // Ascending channel scan: a later (higher) channel overrides the value on a shared index.
    always_comb begin
        w_wb_hit = '0;
        w_wb_val = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k] && w_busy[wb_idx_i[k*IDX_W +: IDX_W]]) begin
                w_wb_hit[wb_idx_i[k*IDX_W +: IDX_W]] = 1'b1;
                w_wb_val[wb_idx_i[k*IDX_W +: IDX_W]] = wb_value_i[k*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_entry
        rob_entry #(
            .DATA_W(DATA_W),
            .PREG_W(PREG_W)
        ) u_entry (
            .i_clk        (clk_i),
            .i_rst_n      (reset_ni),
            .i_flush      (flush_i),
            .i_alloc_we   (w_alloc_fire && (w_tail_idx == IDX_W'(e))),
            .i_pc         (alloc_pc_i),
            .i_inst       (alloc_inst_i),
            .i_prd        (alloc_prd_i),
            .i_wb_we      (w_wb_hit[e]),
            .i_wb_value   (w_wb_val[e]),
            .i_commit_clr (w_commit_fire && (w_head_idx == IDX_W'(e))),
            .o_busy       (w_busy[e]),
            .o_done       (w_done[e]),
            .o_pc         (w_pc[e]),
            .o_inst       (w_inst[e]),
            .o_prd        (w_prd[e]),
            .o_value      (w_value[e])
        );
    end

    assign alloc_idx_o    = w_tail_idx;
    assign commit_idx_o   = w_head_idx;
    assign commit_pc_o    = w_pc[w_head_idx];
    assign commit_inst_o  = w_inst[w_head_idx];
    assign commit_prd_o   = w_prd[w_head_idx];
    assign commit_value_o = w_value[w_head_idx];

    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign count_o = r_tail - r_head;
endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed bench for rob_multi_wb at NUM_ENTRIES=8, NUM_WB=3.
module tb_rob_multi_wb;
    localparam int N = 8;
    localparam int IW = 3;
    localparam int NWB = 3;
    localparam int DW = 32;
    localparam int PW = 5;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    logic flush = 1'b0;
    logic alloc_valid = 1'b0;
    logic alloc_ready;
    logic [PW-1:0] alloc_prd = '0;
    logic [31:0] alloc_pc = '0;
    logic [31:0] alloc_inst = '0;
    logic [IW-1:0] alloc_idx;
    logic [NWB-1:0] wb_valid = '0;
    logic [NWB*IW-1:0] wb_idx = '0;
    logic [NWB*DW-1:0] wb_value = '0;
    logic commit_valid;
    logic commit_ready = 1'b0;
    logic [IW-1:0] commit_idx;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic [PW-1:0] commit_prd;
    logic [DW-1:0] commit_value;
    logic empty, full;
    logic [IW:0] count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_multi_wb #(.NUM_ENTRIES(N), .IDX_W(IW), .NUM_WB(NWB), .DATA_W(DW), .PREG_W(PW)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_prd_i(alloc_prd),
        .alloc_pc_i(alloc_pc), .alloc_inst_i(alloc_inst), .alloc_idx_o(alloc_idx),
        .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_value_i(wb_value),
        .commit_valid_o(commit_valid), .commit_ready_i(commit_ready), .commit_idx_o(commit_idx),
        .commit_pc_o(commit_pc), .commit_inst_o(commit_inst), .commit_prd_o(commit_prd),
        .commit_value_o(commit_value), .empty_o(empty), .full_o(full), .count_o(count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int k, input logic [IW-1:0] idx, input logic [DW-1:0] val);
        wb_valid[k] = 1'b1;
        wb_idx[k*IW +: IW] = idx;
        wb_value[k*DW +: DW] = val;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        flush = 1'b0; alloc_valid = 1'b0; commit_ready = 1'b0; wb_valid = '0;
        step(); step();
        reset_ni = 1'b1;
        #1;
    endtask

    task automatic alloc_n(input int n, input logic [31:0] pc_base);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_pc = pc_base + 32'(4 * i);
            alloc_inst = 32'h13 + 32'(i);
            alloc_prd = PW'(i + 1);
            step();
        end
        alloc_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL rst_alloc_ready got=%0h exp=1", alloc_ready); end
        checks++; if (alloc_idx !== 3'd0) begin failures++; $display("FAIL rst_alloc_idx got=%0h exp=0", alloc_idx); end
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL rst_commit_valid got=%0h exp=0", commit_valid); end
        checks++; if (commit_idx !== 3'd0 || commit_pc !== 32'd0 || commit_inst !== 32'd0 || commit_prd !== 5'd0 || commit_value !== 32'd0)
            begin failures++; $display("FAIL rst_commit_data idx=%0h pc=%0h inst=%0h prd=%0h val=%0h exp=all0", commit_idx, commit_pc, commit_inst, commit_prd, commit_value); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0)
            begin failures++; $display("FAIL rst_occupancy empty=%0h full=%0h count=%0d exp=1/0/0", empty, full, count); end
    endtask

    task automatic test_alloc4();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            alloc_pc = 32'h100 + 32'(4 * i);
            alloc_inst = 32'h13 + 32'(i);
            alloc_prd = PW'(i + 1);
            #1;
            checks++; if (alloc_idx !== IW'(i)) begin failures++; $display("FAIL alloc_idx got=%0d exp=%0d", alloc_idx, i); end
            checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL alloc_commit_valid got=%0h exp=0", commit_valid); end
            step();
        end
        alloc_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL alloc_count got=%0d exp=4", count); end
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL alloc_nowb_commit got=%0h exp=0", commit_valid); end
    endtask

    task automatic test_ooo_wb();
        set_wb(0, 3'd2, 32'hA2); step(); wb_valid = '0;
        set_wb(0, 3'd1, 32'hA1); step(); wb_valid = '0;
        set_wb(0, 3'd3, 32'hA3); step(); wb_valid = '0;
        #1;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_head_not_done got=%0h exp=0", commit_valid); end
        set_wb(0, 3'd0, 32'hA0);
        commit_ready = 1'b1;
        #1;
        checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ooo_no_bypass got=%0h exp=0", commit_valid); end
        step();
        wb_valid = '0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (commit_valid !== 1'b1 || commit_idx !== IW'(j) || commit_value !== 32'hA0 + 32'(j) ||
                commit_pc !== 32'h100 + 32'(4 * j) || commit_prd !== PW'(j + 1)) begin
                failures++;
                $display("FAIL ooo_commit%0d v=%0h idx=%0d val=%0h pc=%0h prd=%0d exp=1/%0d/%0h/%0h/%0d",
                         j, commit_valid, commit_idx, commit_value, commit_pc, commit_prd, j, 32'hA0 + j, 32'h100 + 4 * j, j + 1);
            end
            step();
        end
        commit_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || count !== 4'd0 || commit_valid !== 1'b0)
            begin failures++; $display("FAIL ooo_drained empty=%0h count=%0d cv=%0h exp=1/0/0", empty, count, commit_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < N; i++) begin
            alloc_valid = 1'b1;
            alloc_pc = 32'h200 + 32'(4 * i);
            #1;
            checks++; if (alloc_idx !== IW'(i) || alloc_ready !== 1'b1)
                begin failures++; $display("FAIL fill_idx got=%0d rdy=%0h exp=%0d/1", alloc_idx, alloc_ready, i); end
            step();
        end
        #1;
        checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 4'd8)
            begin failures++; $display("FAIL fill_full full=%0h rdy=%0h count=%0d exp=1/0/8", full, alloc_ready, count); end
        alloc_valid = 1'b0;
        step();
    endtask

    task automatic test_full_commit();
        set_wb(0, 3'd0, 32'h70); step(); wb_valid = '0;
        alloc_valid = 1'b1; alloc_pc = 32'h280; commit_ready = 1'b1;
        #1;
        checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1 || commit_idx !== 3'd0)
            begin failures++; $display("FAIL full_commit_cycle rdy=%0h cv=%0h cidx=%0d exp=0/1/0", alloc_ready, commit_valid, commit_idx); end
        step();
        commit_ready = 1'b0;
        #1;
        checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 3'd0 || count !== 4'd7)
            begin failures++; $display("FAIL full_next_alloc rdy=%0h idx=%0d count=%0d exp=1/0/7", alloc_ready, alloc_idx, count); end
        step();
        alloc_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd8 || full !== 1'b1)
            begin failures++; $display("FAIL full_refill count=%0d full=%0h exp=8/1", count, full); end
    endtask

    task automatic test_wrap();
        set_wb(0, 3'd1, 32'h71); set_wb(1, 3'd2, 32'h72); step(); wb_valid = '0;
        commit_ready = 1'b1;
        for (int j = 1; j < 3; j++) begin
            checks++; if (commit_valid !== 1'b1 || commit_idx !== IW'(j) || commit_value !== 32'h70 + 32'(j))
                begin failures++; $display("FAIL wrap_commit v=%0h idx=%0d val=%0h exp=1/%0d/%0h", commit_valid, commit_idx, commit_value, j, 32'h70 + j); end
            step();
        end
        commit_ready = 1'b0;
        alloc_valid = 1'b1;
        for (int j = 1; j < 3; j++) begin
            #1;
            checks++; if (alloc_idx !== IW'(j) || alloc_ready !== 1'b1)
                begin failures++; $display("FAIL wrap_alloc idx=%0d rdy=%0h exp=%0d/1", alloc_idx, alloc_ready, j); end
            step();
        end
        alloc_valid = 1'b0;
        #1;
        checks++; if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0 || commit_idx !== 3'd3)
            begin failures++; $display("FAIL wrap_final count=%0d full=%0h empty=%0h head=%0d exp=8/1/0/3", count, full, empty, commit_idx); end
    endtask

    task automatic test_wb_conflict();
        do_reset();
        alloc_n(6, 32'h400);
        set_wb(0, 3'd5, 32'h11); set_wb(1, 3'd0, 32'h50); set_wb(2, 3'd5, 32'h22); step(); wb_valid = '0;
        set_wb(0, 3'd6, 32'h66); set_wb(1, 3'd1, 32'h51); set_wb(2, 3'd2, 32'h52); step(); wb_valid = '0;
        set_wb(0, 3'd3, 32'h53); set_wb(1, 3'd4, 32'h54); step(); wb_valid = '0;
        commit_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            logic [31:0] exp_v;
            exp_v = (j < 5) ? 32'h50 + 32'(j) : 32'h22;
            checks++; if (commit_valid !== 1'b1 || commit_idx !== IW'(j) || commit_value !== exp_v)
                begin failures++; $display("FAIL conflict_commit v=%0h idx=%0d val=%0h exp=1/%0d/%0h", commit_valid, commit_idx, commit_value, j, exp_v); end
            step();
        end
        commit_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || commit_idx !== 3'd6 || commit_value !== 32'd0)
            begin failures++; $display("FAIL nonbusy_wb empty=%0h head=%0d val=%0h exp=1/6/0", empty, commit_idx, commit_value); end
        alloc_valid = 1'b1; alloc_pc = 32'h500;
        set_wb(0, 3'd6, 32'h99);
        step();
        alloc_valid = 1'b0; wb_valid = '0;
        #1;
        checks++; if (commit_valid !== 1'b0 || count !== 4'd1 || commit_value !== 32'd0)
            begin failures++; $display("FAIL alloc_cycle_wb cv=%0h count=%0d val=%0h exp=0/1/0", commit_valid, count, commit_value); end
        set_wb(1, 3'd6, 32'h77); step(); wb_valid = '0;
        checks++; if (commit_valid !== 1'b1 || commit_value !== 32'h77 || commit_pc !== 32'h500)
            begin failures++; $display("FAIL wb_after_alloc cv=%0h val=%0h pc=%0h exp=1/77/500", commit_valid, commit_value, commit_pc); end
        set_wb(0, 3'd6, 32'h78); step(); wb_valid = '0;
        checks++; if (commit_valid !== 1'b1 || commit_value !== 32'h78)
            begin failures++; $display("FAIL wb_overwrite cv=%0h val=%0h exp=1/78", commit_valid, commit_value); end
        commit_ready = 1'b1; step(); commit_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || commit_idx !== 3'd7)
            begin failures++; $display("FAIL conflict_end empty=%0h head=%0d exp=1/7", empty, commit_idx); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5, 32'h300);
        set_wb(0, 3'd0, 32'hB0); set_wb(1, 3'd1, 32'hB1); set_wb(2, 3'd2, 32'hB2); step(); wb_valid = '0;
        set_wb(0, 3'd3, 32'hB3); set_wb(1, 3'd4, 32'hB4); step(); wb_valid = '0;
        checks++; if (commit_valid !== 1'b1 || count !== 4'd5)
            begin failures++; $display("FAIL pre_flush cv=%0h count=%0d exp=1/5", commit_valid, count); end
        flush = 1'b1; commit_ready = 1'b1; alloc_valid = 1'b1; alloc_pc = 32'h3F0;
        #1;
        checks++; if (commit_valid !== 1'b0 || alloc_ready !== 1'b0)
            begin failures++; $display("FAIL flush_cycle cv=%0h rdy=%0h exp=0/0", commit_valid, alloc_ready); end
        step();
        flush = 1'b0; commit_ready = 1'b0; alloc_valid = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || count !== 4'd0 || alloc_idx !== 3'd0 || commit_valid !== 1'b0)
            begin failures++; $display("FAIL post_flush empty=%0h count=%0d idx=%0d cv=%0h exp=1/0/0/0", empty, count, alloc_idx, commit_valid); end
        checks++; if (commit_pc !== 32'h300 || commit_value !== 32'hB0)
            begin failures++; $display("FAIL flush_keeps_data pc=%0h val=%0h exp=300/b0", commit_pc, commit_value); end
    endtask

    initial begin
        test_reset();
        test_alloc4();
        test_ooo_wb();
        test_fill();
        test_full_commit();
        test_wrap();
        test_wb_conflict();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
